spike_event_scheduler: RTL and testbench
========================================

// Module: spike_event_scheduler
// PURPOSE
//  Round-robin scheduler sharing one synapse/weight-accumulate unit among N_NEURONS neuron spike sources.
//  - Latches each neuron's spike into a pending bit.
//  - Grants one pending spike at a time over a valid/ready event port, tagged with the source index and its programmed synaptic weight.
//  - Generates the network timestep tick.
//  - Sits between the neuron array and the shared synapse unit in the top level.
// PARAMETERS
//  N_NEURONS    4   number of spike sources (power of 2, 2..16)
//  IDX_W        2   log2(N_NEURONS)
//  WEIGHT_W     8   synaptic weight width
//  TICK_PERIOD  16  ena-cycles per timestep tick (>=2)
// PORTS
//  clk         in   1          clock, all logic on rising edge
//  rst_n       in   1          synchronous active-low reset
//  ena         in   1          design enable; low freezes capture, arbitration and tick counter
//  spike_in    in   N_NEURONS  spike[i]=1 in a cycle requests one event for neuron i
//  cfg_we      in   1          weight write strobe
//  cfg_idx     in   IDX_W      weight register to write
//  cfg_weight  in   WEIGHT_W   weight write data
//  ev_valid    out  1          event offered to synapse unit
//  ev_ready    in   1          synapse unit accepts event
//  ev_idx      out  IDX_W      source neuron of offered event
//  ev_weight   out  WEIGHT_W   weight of offered event
//  pending     out  N_NEURONS  registered pending-spike bits
//  overflow    out  1          sticky: a spike arrived for an already-pending neuron
//  tick        out  1          one-cycle timestep pulse
// BEHAVIOUR
//  Reset: ev_valid=0, ev_idx=0, ev_weight=0, pending=0, overflow=0, tick=0, rr_ptr=0, tick_cnt=0, all weight regs=1, state IDLE.
//  Capture (ena=1): spike_in[i]=1 sets pending[i] next cycle.
//   - If pending[i] already 1 and not cleared this cycle: spike dropped, overflow<=1 (cleared only by reset).
//   - Spike on index being cleared by a grant in the same cycle: pending[i] stays 1, no overflow.
//  Selection: first set bit of pending scanning rr_ptr, rr_ptr+1, ... mod N_NEURONS.
//  FSM:
//   - IDLE: if ena and pending!=0, load selected idx into ev_idx, weight[idx] into ev_weight, ev_valid<=1, clear pending[idx]; ->OFFER.
//   - OFFER: ev_idx/ev_weight/ev_valid held stable until ev_valid&&ev_ready.
//     On handshake: rr_ptr<=ev_idx+1 (wraps).
//     If ena and another pending bit is set, load it the same edge (scan from ev_idx+1), stay OFFER; else ev_valid<=0, ->IDLE.
//   - Sustained ev_ready=1 gives one event per cycle.
//  Latency: spike at edge t -> pending at t+1 -> ev_valid at t+2 (scheduler idle).
//  ena=0: no capture, no new load; an outstanding offer stays valid and may still complete; FSM returns to IDLE after it.
//  Weights: cfg_we writes weight[cfg_idx] next edge regardless of ena. Write to the index currently offered does not alter held ev_weight; it applies to the next event from that index.
//  Tick: tick_cnt increments on ena cycles and wraps at TICK_PERIOD-1; tick=1 for the cycle after the wrap edge.
//  Reset mid-offer: event discarded, all state to reset values, no handshake implied.
// TESTING
//  1. Reset, spike_in=4'b0001 one cycle, ev_ready=1 -> ev_valid=1 two cycles later, ev_idx=0, ev_weight=1; pending=0 after.
//  2. spike_in=4'b1111 once, ev_ready=1 -> ev_idx 0,1,2,3 on consecutive cycles, then ev_valid=0, overflow=0.
//  3. cfg write weight[2]=8'hA5; spike_in=4'b0100, ev_ready=0 for 5 cycles -> ev_valid/ev_idx=2/ev_weight=A5 stable, accepted when ready=1.
//  4. spike_in[1] twice while pending[1]=1 and ev_ready=0 -> overflow=1 and remains 1; exactly one idx-1 event is delivered.
//  5. Fairness: hold spike_in=4'b0011 every cycle, ev_ready=1 -> ev_idx alternates 0,1,0,1; no starvation.
//  6. ena=0 during offer -> offer completes on ready, no new events or ticks; TICK_PERIOD=16 with ena=1 -> tick every 16 cycles; rst_n=0 mid-offer -> ev_valid=0 next edge.

Source files
------------

// File: rtl/spike_event_scheduler.sv
// spike_event_scheduler: round-robin arbiter that shares one synapse/weight-accumulate
// unit among N_NEURONS spike sources, and also generates the network timestep tick.
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   ena                    enable; low freezes spike capture, new grants and the tick counter
//   spike_in               one-cycle spike requests, one bit per neuron
//   cfg_we/cfg_idx/cfg_weight  weight register write port (not gated by ena)
//   ev_valid/ev_ready      event handshake toward the synapse unit
//   ev_idx/ev_weight       source neuron and synaptic weight of the offered event
//   pending                latched spike bits that have not been granted yet
//   overflow               sticky flag: a spike was dropped because its neuron was already pending
//   tick                   one-cycle timestep pulse
module spike_event_scheduler #(
  parameter int unsigned N_NEURONS   = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned WEIGHT_W    = 8,
  parameter int unsigned TICK_PERIOD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [WEIGHT_W-1:0]  cfg_weight,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [IDX_W-1:0]     ev_idx,
  output logic [WEIGHT_W-1:0]  ev_weight,
  output logic [N_NEURONS-1:0] pending,
  output logic                 overflow,
  output logic                 tick
);

  localparam int unsigned CNT_W = (TICK_PERIOD > 2) ? $clog2(TICK_PERIOD) : 1;

  typedef enum logic {IDLE, OFFER} state_e;

  state_e               state_q, state_d;
  logic                 ev_valid_q, ev_valid_d;
  logic [IDX_W-1:0]     ev_idx_q, ev_idx_d;
  logic [WEIGHT_W-1:0]  ev_weight_q, ev_weight_d;
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic                 overflow_q, overflow_d;
  logic                 tick_q, tick_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [WEIGHT_W-1:0]  weight_q [N_NEURONS];
  logic [WEIGHT_W-1:0]  weight_d [N_NEURONS];

  logic                 grant_en;
  logic [IDX_W-1:0]     grant_idx;
  logic [N_NEURONS-1:0] clr;
  logic [IDX_W-1:0]     sel_rr, sel_next;

  // First set bit of req scanning start, start+1, ... (index arithmetic wraps mod N).
  // Iterating from the largest offset down leaves the smallest offset as the result.
  function automatic logic [IDX_W-1:0] pick(input logic [N_NEURONS-1:0] req,
                                            input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] idx;
    res = start;
    for (int k = int'(N_NEURONS) - 1; k >= 0; k--) begin
      idx = start + IDX_W'(k);
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

  assign sel_rr   = pick(pending_q, rr_ptr_q);
  assign sel_next = pick(pending_q, ev_idx_q + IDX_W'(1));

  // Grant FSM, spike capture, weight writes and tick counter.
  always_comb begin
    state_d     = state_q;
    ev_valid_d  = ev_valid_q;
    ev_idx_d    = ev_idx_q;
    ev_weight_d = ev_weight_q;
    rr_ptr_d    = rr_ptr_q;
    tick_cnt_d  = tick_cnt_q;
    tick_d      = 1'b0;
    grant_en    = 1'b0;
    grant_idx   = '0;
    clr         = '0;
    weight_d    = weight_q;

    unique case (state_q)
      IDLE: begin
        if (ena && (|pending_q)) begin
          grant_en  = 1'b1;
          grant_idx = sel_rr;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          rr_ptr_d = ev_idx_q + IDX_W'(1);
          if (ena && (|pending_q)) begin
            grant_en  = 1'b1;
            grant_idx = sel_next;
          end else begin
            ev_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The granted weight is read before this cycle's cfg write takes effect.
    if (grant_en) begin
      ev_idx_d        = grant_idx;
      ev_weight_d     = weight_q[grant_idx];
      ev_valid_d      = 1'b1;
      state_d         = OFFER;
      clr[grant_idx]  = 1'b1;
    end

    // A spike on the bit being granted re-arms it instead of counting as overflow.
    pending_d  = (pending_q & ~clr) | (ena ? spike_in : '0);
    overflow_d = overflow_q | (ena & (|(spike_in & pending_q & ~clr)));

    if (cfg_we) weight_d[cfg_idx] = cfg_weight;

    if (ena) begin
      if (tick_cnt_q == CNT_W'(TICK_PERIOD - 1)) begin
        tick_cnt_d = '0;
        tick_d     = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ev_valid_q  <= 1'b0;
      ev_idx_q    <= '0;
      ev_weight_q <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      tick_q      <= 1'b0;
      rr_ptr_q    <= '0;
      tick_cnt_q  <= '0;
      for (int i = 0; i < int'(N_NEURONS); i++) weight_q[i] <= WEIGHT_W'(1);
    end else begin
      state_q     <= state_d;
      ev_valid_q  <= ev_valid_d;
      ev_idx_q    <= ev_idx_d;
      ev_weight_q <= ev_weight_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      tick_q      <= tick_d;
      rr_ptr_q    <= rr_ptr_d;
      tick_cnt_q  <= tick_cnt_d;
      weight_q    <= weight_d;
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_idx    = ev_idx_q;
  assign ev_weight = ev_weight_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Testbench for spike_event_scheduler: a vector table, directed corner-case sequences and a
// randomized run compared against an event-level reference model.
module tb_spike_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] spike_in;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_weight;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_idx;
  logic [7:0] ev_weight;
  logic [3:0] pending;
  logic       overflow;
  logic       tick;

  int checks   = 0;
  int failures = 0;

  spike_event_scheduler #(
    .N_NEURONS(4), .IDX_W(2), .WEIGHT_W(8), .TICK_PERIOD(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx), .ev_weight(ev_weight),
    .pending(pending), .overflow(overflow), .tick(tick)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; spike_in = '0; ev_ready = 1'b0; cfg_we = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (event level) ----------------
  bit      m_pend [4];
  bit      m_ovf, m_busy, m_tick;
  int      m_rr, m_idx, m_cnt;
  int      m_w;
  int      m_wt [4];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_wt[i] = 1; end
    m_ovf = 0; m_busy = 0; m_tick = 0; m_rr = 0; m_idx = 0; m_cnt = 0; m_w = 0;
  endfunction

  function automatic int first_from(input int start);
    for (int off = 0; off < 4; off++)
      if (m_pend[(start + off) % 4]) return (start + off) % 4;
    return -1;
  endfunction

  function automatic void model_step();
    int  g;
    bit  any;
    g = -1;
    any = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
    if (!m_busy) begin
      if (ena && any) g = first_from(m_rr);
    end else if (ev_ready) begin
      m_rr = (m_idx + 1) % 4;
      if (ena && any) g = first_from((m_idx + 1) % 4);
      else m_busy = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (ena && spike_in[i] && m_pend[i] && g != i) m_ovf = 1;
      m_pend[i] = (m_pend[i] && g != i) || (ena && spike_in[i]);
    end
    if (g >= 0) begin m_busy = 1; m_idx = g; m_w = m_wt[g]; end
    if (cfg_we) m_wt[cfg_idx] = int'(cfg_weight);
    m_tick = 0;
    if (ena) begin
      if (m_cnt == 15) begin m_cnt = 0; m_tick = 1; end
      else m_cnt++;
    end
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [3:0] spike;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_idx;
    logic [7:0] exp_weight;
    logic [3:0] exp_pend;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n_idx1;
    logic [3:0] mp;

    vecs[0] = '{1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0001, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h01, 4'b0000, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h01, 4'b0000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 8'h01, 4'b1110, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 8'h01, 4'b1100, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h01, 4'b1000, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 8'h01, 4'b0000, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd3, 8'h01, 4'b0000, 1'b0};

    cfg_idx = '0; cfg_weight = '0;
    do_reset();
    chk("reset_valid", 32'(ev_valid), 32'd0);
    chk("reset_idx", 32'(ev_idx), 32'd0);
    chk("reset_weight", 32'(ev_weight), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);

    // Single event latency, then burst of four drained one per cycle.
    for (int r = 0; r < 10; r++) begin
      rst_n = vecs[r].rst_n; ena = vecs[r].ena;
      spike_in = vecs[r].spike; ev_ready = vecs[r].ready;
      step();
      chk($sformatf("vec%0d_valid", r), 32'(ev_valid), 32'(vecs[r].exp_valid));
      chk($sformatf("vec%0d_idx", r), 32'(ev_idx), 32'(vecs[r].exp_idx));
      chk($sformatf("vec%0d_weight", r), 32'(ev_weight), 32'(vecs[r].exp_weight));
      chk($sformatf("vec%0d_pending", r), 32'(pending), 32'(vecs[r].exp_pend));
      chk($sformatf("vec%0d_overflow", r), 32'(overflow), 32'(vecs[r].exp_ovf));
    end
    rst_n = 1'b1;

    // Stalled offer keeps its fields; a weight write to the offered index only affects later events.
    do_reset();
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_weight = 8'hA5;
    step();
    cfg_we = 1'b0; spike_in = 4'b0100;
    step();
    spike_in = 4'b0000;
    step();
    chk("stall_valid0", 32'(ev_valid), 32'd1);
    chk("stall_weight0", 32'(ev_weight), 32'hA5);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_weight = 8'h11;
    for (int c = 0; c < 5; c++) begin
      step();
      cfg_we = 1'b0;
      chk($sformatf("stall%0d_valid", c), 32'(ev_valid), 32'd1);
      chk($sformatf("stall%0d_idx", c), 32'(ev_idx), 32'd2);
      chk($sformatf("stall%0d_weight", c), 32'(ev_weight), 32'hA5);
    end
    ev_ready = 1'b1;
    step();
    chk("stall_accept_valid", 32'(ev_valid), 32'd0);
    spike_in = 4'b0100;
    step();
    spike_in = 4'b0000;
    step();
    chk("new_weight_idx", 32'(ev_idx), 32'd2);
    chk("new_weight_val", 32'(ev_weight), 32'h11);
    step();

    // Overflow: neuron 1 spikes twice while already pending behind a stalled neuron-0 offer.
    do_reset();
    spike_in = 4'b0001;
    step();
    spike_in = 4'b0000;
    step();
    spike_in = 4'b0010;
    step();
    chk("ovf_first_spike", 32'(overflow), 32'd0);
    step();
    chk("ovf_set", 32'(overflow), 32'd1);
    step();
    spike_in = 4'b0000;
    ev_ready = 1'b1;
    n_idx1 = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (ev_valid && ev_idx == 2'd1) n_idx1++;
    end
    chk("ovf_one_event", 32'(n_idx1), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Spike on the index being granted in the same cycle re-arms it without overflow.
    do_reset();
    ev_ready = 1'b0; spike_in = 4'b0010;
    step();
    step();
    chk("rearm_valid", 32'(ev_valid), 32'd1);
    chk("rearm_idx", 32'(ev_idx), 32'd1);
    chk("rearm_pending", 32'(pending), 32'b0010);
    chk("rearm_overflow", 32'(overflow), 32'd0);
    spike_in = 4'b0000;

    // Fairness under sustained requests from neurons 0 and 1.
    do_reset();
    spike_in = 4'b0011; ev_ready = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("fair%0d_valid", c), 32'(ev_valid), 32'd1);
      chk($sformatf("fair%0d_idx", c), 32'(ev_idx), 32'(c % 2));
    end
    spike_in = 4'b0000;

    // ena=0 mid-offer: offer completes, nothing captured, no new grant, no tick.
    do_reset();
    spike_in = 4'b0011;
    step();
    spike_in = 4'b0000;
    step();
    chk("ena_offer_idx", 32'(ev_idx), 32'd0);
    ena = 1'b0; spike_in = 4'b1100;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("ena_hold%0d", c), 32'(ev_valid), 32'd1);
    end
    ev_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("ena_off%0d_valid", c), 32'(ev_valid), 32'd0);
      chk($sformatf("ena_off%0d_tick", c), 32'(tick), 32'd0);
    end
    chk("ena_off_pending", 32'(pending), 32'b0010);
    ena = 1'b1; spike_in = 4'b0000;
    step();
    chk("ena_resume_idx", 32'(ev_idx), 32'd1);
    chk("ena_resume_valid", 32'(ev_valid), 32'd1);

    // Tick every 16 enabled cycles.
    do_reset();
    ev_ready = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      chk($sformatf("tick_k%0d", k), 32'(tick), 32'((k % 16) == 0));
    end

    // Reset in the middle of an offer discards it.
    do_reset();
    ev_ready = 1'b0; spike_in = 4'b0101;
    step();
    spike_in = 4'b0000;
    step();
    chk("rstmid_pre", 32'(ev_valid), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rstmid_valid", 32'(ev_valid), 32'd0);
    chk("rstmid_pending", 32'(pending), 32'd0);
    rst_n = 1'b1;

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      mp = {m_pend[3], m_pend[2], m_pend[1], m_pend[0]};
      chk($sformatf("rnd%0d_valid", c), 32'(ev_valid), 32'(m_busy));
      if (m_busy) begin
        chk($sformatf("rnd%0d_idx", c), 32'(ev_idx), 32'(m_idx));
        chk($sformatf("rnd%0d_weight", c), 32'(ev_weight), 32'(m_w));
      end
      chk($sformatf("rnd%0d_pending", c), 32'(pending), 32'(mp));
      chk($sformatf("rnd%0d_overflow", c), 32'(overflow), 32'(m_ovf));
      chk($sformatf("rnd%0d_tick", c), 32'(tick), 32'(m_tick));
      ena        = ($urandom_range(0, 9) != 0);
      spike_in   = 4'($urandom) & 4'($urandom);
      ev_ready   = ($urandom_range(0, 9) < 7);
      cfg_we     = ($urandom_range(0, 9) == 0);
      cfg_idx    = 2'($urandom);
      cfg_weight = 8'($urandom);
      model_step();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
